lifo_arbiter: RTL
=================

LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data width of requesters and stack.
REQ-002 Parameter DEPTH, default 16, depth of the attached LIFOBlock; not used in logic, for documentation and bench only.
REQ-003 clock  in  1  single clock; all state on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_a, req_b  in  1 each  requester A (call/return unit) / B (interrupt context unit) beat request.
REQ-006 op_a, op_b  in  1 each  1 = push, 0 = pop; valid while req_x high.
REQ-007 last_a, last_b  in  1 each  final beat of burst; 0 keeps ownership after this beat.
REQ-008 wdata_a, wdata_b  in  WIDTH each  push data.
REQ-009 flush  in  1  request to empty the stack.
REQ-010 gnt_a, gnt_b  out  1 each  combinational; beat accepted this cycle.
REQ-011 rvalid_a, rvalid_b  out  1 each  registered; pop data valid on rdata.
REQ-012 rdata  out  WIDTH  pop data, shared by both requesters.
REQ-013 err_ovf, err_unf  out  1 each  sticky overflow / underflow flags.
REQ-014 lifo_push, lifo_pop, lifo_reset  out  1 each  drive LIFOBlock push, pop, reset.
REQ-015 lifo_data  out  WIDTH  drives LIFOBlock data.
REQ-016 lifo_q  in  WIDTH; lifo_full, lifo_empty  in  1 each  from LIFOBlock.

Function
REQ-017 FSM states IDLE, OWN_A, OWN_B; at most one gnt and at most one LIFO operation per cycle.
REQ-018 IDLE, one requester active: grant it; both active: grant the requester not served last (rr_last register, reset value B, so A wins first tie).
REQ-019 Granted beat with last_x = 0: next state OWN_x; with last_x = 1: stay IDLE; rr_last <= x in both cases.
REQ-020 OWN_x: only x is granted (gnt_x = req_x); other requester stalls regardless of priority; beat with last_x = 1 returns to IDLE.
REQ-021 Accepted push with lifo_full = 0: lifo_push = 1, lifo_data = wdata_x same cycle.
REQ-022 Accepted pop with lifo_empty = 0: lifo_pop = 1 same cycle; next cycle rvalid_x = 1 and rdata = lifo_q (one-cycle latency).
REQ-023 Accepted push with lifo_full = 1: beat consumed, no LIFO op, err_ovf <= 1.
REQ-024 Accepted pop with lifo_empty = 1: beat consumed, no LIFO op, err_unf <= 1; next cycle rvalid_x = 1, rdata = 0.
REQ-025 lifo_push and lifo_pop never both high; lifo_data = 0 when lifo_push = 0.
REQ-026 flush in IDLE: lifo_reset = 1 for exactly that cycle, no grants, err_ovf/err_unf cleared next edge; flush outside IDLE ignored until IDLE is reached, then honoured if still high.
REQ-027 Flush and requests in the same IDLE cycle: flush wins.
REQ-028 req_x dropping during OWN_x: ownership retained, bus stays locked until last beat.
REQ-029 rdata holds its last value when no rvalid.

Reset
REQ-030 reset_n low: state IDLE, rr_last = B, rvalid_a = rvalid_b = 0, rdata = 0, err_ovf = err_unf = 0, gnt_a = gnt_b = lifo_push = lifo_pop = 0, all immediately and asynchronously.
REQ-031 lifo_reset = 1 combinationally while reset_n = 0, and held 1 for the first clock edge after reset_n rises.
REQ-032 Reset mid-burst aborts ownership; no partial-burst state survives.

Verification
REQ-033 After reset, A pushes 0x1111 (last=1), then A pops -> gnt_a both cycles, rvalid_a one cycle after pop, rdata = 0x1111.
REQ-034 req_a and req_b both high from IDLE, single-beat pushes, three cycles -> grant order A, B, A.
REQ-035 B bursts three pushes 0xB0, 0xB1, 0xB2 (last on third) while req_a high -> gnt_a = 0 until B's last beat; three pops then return 0xB2, 0xB1, 0xB0.
REQ-036 Push 16 words (DEPTH = 16), 17th push -> gnt high, lifo_push = 0, err_ovf = 1 next cycle; stack contents unchanged.
REQ-037 Pop on empty stack -> err_unf = 1, rvalid with rdata = 0; flush in IDLE -> lifo_reset one cycle, err flags 0, lifo_empty = 1.
REQ-038 reset_n pulsed low during OWN_A -> outputs at reset values asynchronously; after release, B request granted in IDLE.

Source files
------------

// File: rtl/lifo_arbiter_if.sv
// Requester, flush and LIFOBlock signals shared between the arbiter and its environment.
// A beat transfers in a cycle where req_x && gnt_x; gnt_x is combinational, so op_x/last_x/wdata_x must be stable while req_x is high.
interface lifo_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req_a;
    logic             req_b;
    logic             op_a;
    logic             op_b;
    logic             last_a;
    logic             last_b;
    logic [WIDTH-1:0] wdata_a;
    logic [WIDTH-1:0] wdata_b;
    logic             flush;
    logic             gnt_a;
    logic             gnt_b;
    logic             rvalid_a;
    logic             rvalid_b;
    logic [WIDTH-1:0] rdata;
    logic             err_ovf;
    logic             err_unf;
    logic             lifo_push;
    logic             lifo_pop;
    logic             lifo_reset;
    logic [WIDTH-1:0] lifo_data;
    logic [WIDTH-1:0] lifo_q;
    logic             lifo_full;
    logic             lifo_empty;

    modport slave (
        input  req_a, req_b, op_a, op_b, last_a, last_b, wdata_a, wdata_b, flush,
        input  lifo_q, lifo_full, lifo_empty,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, err_ovf, err_unf,
        output lifo_push, lifo_pop, lifo_reset, lifo_data
    );

    modport master (
        output req_a, req_b, op_a, op_b, last_a, last_b, wdata_a, wdata_b, flush,
        output lifo_q, lifo_full, lifo_empty,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, err_ovf, err_unf,
        input  lifo_push, lifo_pop, lifo_reset, lifo_data
    );
endinterface

// File: rtl/lifo_arbiter.sv
// Two-requester arbiter in front of a single LIFOBlock: round-robin on ties, burst
// ownership until the last beat, overflow/underflow absorption and flush control.
module lifo_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    lifo_arbiter_if.slave       bus,
    output logic [1:0]          state_dbg
);

    if (DEPTH < 1) begin : g_depth_check
        $error("lifo_arbiter: DEPTH must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             sel_a;
    logic             sel_b;
    logic             flush_take;
    logic             rr_last_b;
    logic             init_rst;
    logic             gnt_a;
    logic             gnt_b;
    logic             beat;
    logic             beat_op;
    logic [WIDTH-1:0] beat_wdata;
    logic             push;
    logic             pop;
    logic             rvalid_a;
    logic             rvalid_b;
    logic [WIDTH-1:0] rdata;
    logic             err_ovf;
    logic             err_unf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration decision and next state; flush in IDLE blocks every grant.
    always_comb begin
        sel_a      = 1'b0;
        sel_b      = 1'b0;
        flush_take = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                if (bus.flush) begin
                    flush_take = 1'b1;
                end else if (bus.req_a && bus.req_b) begin
                    sel_a = rr_last_b;
                    sel_b = !rr_last_b;
                end else begin
                    sel_a = bus.req_a;
                    sel_b = bus.req_b;
                end
            end
            OWN_A:   sel_a = bus.req_a;
            OWN_B:   sel_b = bus.req_b;
            default: state_nxt = IDLE;
        endcase
        if (sel_a) begin
            state_nxt = bus.last_a ? IDLE : OWN_A;
        end else if (sel_b) begin
            state_nxt = bus.last_b ? IDLE : OWN_B;
        end
    end

    always_comb begin
        gnt_a      = sel_a && reset_n;
        gnt_b      = sel_b && reset_n;
        beat       = gnt_a || gnt_b;
        beat_op    = sel_a ? bus.op_a : bus.op_b;
        beat_wdata = sel_a ? bus.wdata_a : bus.wdata_b;
        push       = beat && beat_op && !bus.lifo_full;
        pop        = beat && !beat_op && !bus.lifo_empty;
        state_dbg  = state;
    end

    // init_rst keeps lifo_reset high through the first edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_b <= 1'b1;
            init_rst  <= 1'b1;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            rdata     <= '0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            init_rst <= 1'b0;
            rvalid_a <= gnt_a && !bus.op_a;
            rvalid_b <= gnt_b && !bus.op_b;
            if (gnt_a) begin
                rr_last_b <= 1'b0;
            end else if (gnt_b) begin
                rr_last_b <= 1'b1;
            end
            if (beat && !beat_op) begin
                rdata <= bus.lifo_empty ? '0 : bus.lifo_q;
            end
            if (flush_take) begin
                err_ovf <= 1'b0;
                err_unf <= 1'b0;
            end else begin
                if (beat && beat_op && bus.lifo_full) begin
                    err_ovf <= 1'b1;
                end
                if (beat && !beat_op && bus.lifo_empty) begin
                    err_unf <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt_a      = gnt_a;
    assign bus.gnt_b      = gnt_b;
    assign bus.rvalid_a   = rvalid_a;
    assign bus.rvalid_b   = rvalid_b;
    assign bus.rdata      = rdata;
    assign bus.err_ovf    = err_ovf;
    assign bus.err_unf    = err_unf;
    assign bus.lifo_push  = push;
    assign bus.lifo_pop   = pop;
    assign bus.lifo_data  = push ? beat_wdata : '0;
    assign bus.lifo_reset = !reset_n || init_rst || flush_take;

endmodule
